// File: rtl/display_source_arbiter.sv
// display_source_arbiter: shares one 64-bit dot-matrix display word between
// NUM_SRC producers. The granted word is latched into disp_data and the owner
// is held for at least MIN_HOLD cycles so every shown word survives a full
// refresh. Ownership rotates round-robin; pin_en/pin_sel narrow eligibility.
module display_source_arbiter #(
    parameter int unsigned NUM_SRC  = 3,
    parameter int unsigned MIN_HOLD = 40000,
    parameter int unsigned HOLD_W   = 16
) (
    input  logic                  clock_27mhz,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic [NUM_SRC*64-1:0] src_data,
    output logic [NUM_SRC-1:0]    src_ack,
    input  logic                  pin_en,
    input  logic [1:0]            pin_sel,
    output logic [63:0]           disp_data,
    output logic [1:0]            disp_owner,
    output logic                  disp_valid,
    output logic                  hold_busy
);

    typedef enum logic [1:0] {StIdle, StShow, StOpen} state_e;

    localparam logic [HOLD_W-1:0] HoldLoad = HOLD_W'(MIN_HOLD - 1);

    state_e               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [1:0]           owner_q, owner_d;
    logic [63:0]          data_q, data_d;
    logic                 valid_q, valid_d;
    logic [NUM_SRC-1:0]   ack_q;
    logic [3:0]           ack_d;

    logic [NUM_SRC-1:0]   elig;
    // Zero-padded to the full 2-bit index range so any owner index is safe.
    logic [3:0]           elig_ext;
    logic [255:0]         data_ext;

    logic                 idle_found, open_found;
    logic [1:0]           idle_sel, open_sel;
    logic                 cap_en;
    logic [1:0]           cap_sel;

    // Index (base + k) modulo NUM_SRC; base <= NUM_SRC and k < NUM_SRC.
    function automatic logic [1:0] wrap_idx(input int unsigned base, input int unsigned k);
        int unsigned s;
        s = base + k;
        if (s >= NUM_SRC) begin
            s = s - NUM_SRC;
        end
        return s[1:0];
    endfunction

    // Eligibility: requesting, not in its ack cycle, and allowed by the pin.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            elig[i] = src_req[i] & ~ack_q[i] & (~pin_en | (pin_sel == 2'(i)));
        end
    end

    assign elig_ext = 4'(elig);
    assign data_ext = 256'(src_data);

    // Round-robin searches: from rr_ptr for IDLE, from owner+1 skipping owner for OPEN.
    always_comb begin
        logic [1:0] cand;
        idle_found = 1'b0;
        idle_sel   = 2'd0;
        open_found = 1'b0;
        open_sel   = 2'd0;
        cand       = 2'd0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = wrap_idx(32'(rr_ptr_q), k);
            if (!idle_found && elig_ext[cand]) begin
                idle_found = 1'b1;
                idle_sel   = cand;
            end
        end
        for (int unsigned k = 0; k < NUM_SRC - 1; k++) begin
            cand = wrap_idx(32'(owner_q) + 32'd1, k);
            if (!open_found && elig_ext[cand]) begin
                open_found = 1'b1;
                open_sel   = cand;
            end
        end
    end

    // Next-state: FSM transitions, hold timer and word capture.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ack_d    = 4'd0;
        cap_en   = 1'b0;
        cap_sel  = owner_q;

        unique case (state_q)
            StIdle: begin
                if (idle_found) begin
                    cap_en  = 1'b1;
                    cap_sel = idle_sel;
                    hold_d  = HoldLoad;
                    valid_d = 1'b1;
                    state_d = StShow;
                end
            end
            StShow: begin
                // Owner may refresh its word, but the hold is never restarted.
                if (elig_ext[owner_q]) begin
                    cap_en  = 1'b1;
                    cap_sel = owner_q;
                end
                if (hold_q == '0) begin
                    state_d = StOpen;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            StOpen: begin
                // A waiting non-owner beats the owner; owner's request stays pending.
                if (open_found) begin
                    cap_en   = 1'b1;
                    cap_sel  = open_sel;
                    rr_ptr_d = wrap_idx(32'(open_sel), 32'd1);
                    hold_d   = HoldLoad;
                    state_d  = StShow;
                end else if (elig_ext[owner_q]) begin
                    cap_en  = 1'b1;
                    cap_sel = owner_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (cap_en) begin
            ack_d[cap_sel] = 1'b1;
            owner_d        = cap_sel;
            data_d         = data_ext[64*cap_sel +: 64];
        end
    end

    // State and output registers; reset drops owner, word and pointer at once.
    always_ff @(posedge clock_27mhz or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            rr_ptr_q <= 2'd0;
            owner_q  <= 2'd0;
            data_q   <= 64'd0;
            valid_q  <= 1'b0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d[NUM_SRC-1:0];
        end
    end

    assign src_ack    = ack_q;
    assign disp_data  = data_q;
    assign disp_owner = owner_q;
    assign disp_valid = valid_q;
    assign hold_busy  = (state_q == StShow);

endmodule

// File: tb/tb_display_source_arbiter.sv
// Testbench for display_source_arbiter with NUM_SRC=3, MIN_HOLD=8.
module tb_display_source_arbiter;

    localparam int unsigned NUM_SRC  = 3;
    localparam int unsigned MIN_HOLD = 8;
    localparam int unsigned HOLD_W   = 16;

    localparam logic [63:0] D0  = 64'hA0A0_1111_B0B0_2222;
    localparam logic [63:0] D0B = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D1  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2  = 64'h5555_0000_FFFF_3333;

    logic        clock_27mhz;
    logic        reset;
    logic [2:0]  src_req;
    logic [191:0] src_data;
    logic [2:0]  src_ack;
    logic        pin_en;
    logic [1:0]  pin_sel;
    logic [63:0] disp_data;
    logic [1:0]  disp_owner;
    logic        disp_valid;
    logic        hold_busy;

    logic [63:0] w0, w1, w2;
    assign src_data = {w2, w1, w0};

    int errors = 0;
    int checks = 0;

    display_source_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .MIN_HOLD (MIN_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clock_27mhz (clock_27mhz),
        .reset       (reset),
        .src_req     (src_req),
        .src_data    (src_data),
        .src_ack     (src_ack),
        .pin_en      (pin_en),
        .pin_sel     (pin_sel),
        .disp_data   (disp_data),
        .disp_owner  (disp_owner),
        .disp_valid  (disp_valid),
        .hold_busy   (hold_busy)
    );

    initial clock_27mhz = 1'b0;
    always #5 clock_27mhz = ~clock_27mhz;

    initial begin
        #200000;
        $display("FAIL watchdog: got time %0t, required finish before 200000", $time);
        $fatal(1);
    end

    typedef struct {
        logic [2:0] req;
        logic [2:0] ack;
        logic [1:0] owner;
        logic       busy;
        logic       valid;
        logic [1:0] dsel;   // 3 = display word still zero
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_27mhz);
        #1;
    endtask

    task automatic wait_open(input string name);
        int n;
        n = 0;
        while (hold_busy && n < 30) begin
            tick();
            n++;
        end
        check(name, 64'(hold_busy), 64'd0);
    endtask

    function automatic logic [63:0] exp_word(input logic [1:0] dsel);
        case (dsel)
            2'd0:    return D0;
            2'd1:    return D1;
            2'd2:    return D2;
            default: return 64'd0;
        endcase
    endfunction

    initial begin
        int first_k;
        int n;
        int nacks;
        int nev;
        int multi;
        logic [1:0] last_owner;
        logic [1:0] ev_owner [4];
        int ev_t [4];

        // Tests 1 and 2: first grant, 8-cycle hold, waiting non-owner taken on OPEN.
        vecs[0]  = '{3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3};
        vecs[1]  = '{3'b010, 3'b010, 2'd1, 1'b1, 1'b1, 2'd1};
        vecs[2]  = '{3'b000, 3'b000, 2'd1, 1'b1, 1'b1, 2'd1};
        vecs[3]  = '{3'b000, 3'b000, 2'd1, 1'b1, 1'b1, 2'd1};
        vecs[4]  = '{3'b100, 3'b000, 2'd1, 1'b1, 1'b1, 2'd1};
        vecs[5]  = '{3'b100, 3'b000, 2'd1, 1'b1, 1'b1, 2'd1};
        vecs[6]  = '{3'b100, 3'b000, 2'd1, 1'b1, 1'b1, 2'd1};
        vecs[7]  = '{3'b100, 3'b000, 2'd1, 1'b1, 1'b1, 2'd1};
        vecs[8]  = '{3'b100, 3'b000, 2'd1, 1'b1, 1'b1, 2'd1};
        vecs[9]  = '{3'b100, 3'b000, 2'd1, 1'b0, 1'b1, 2'd1};
        vecs[10] = '{3'b100, 3'b100, 2'd2, 1'b1, 1'b1, 2'd2};
        vecs[11] = '{3'b000, 3'b000, 2'd2, 1'b1, 1'b1, 2'd2};
        vecs[12] = '{3'b000, 3'b000, 2'd2, 1'b1, 1'b1, 2'd2};
        vecs[13] = '{3'b000, 3'b000, 2'd2, 1'b1, 1'b1, 2'd2};
        vecs[14] = '{3'b000, 3'b000, 2'd2, 1'b1, 1'b1, 2'd2};
        vecs[15] = '{3'b000, 3'b000, 2'd2, 1'b1, 1'b1, 2'd2};
        vecs[16] = '{3'b000, 3'b000, 2'd2, 1'b1, 1'b1, 2'd2};
        vecs[17] = '{3'b000, 3'b000, 2'd2, 1'b1, 1'b1, 2'd2};
        vecs[18] = '{3'b000, 3'b000, 2'd2, 1'b0, 1'b1, 2'd2};

        w0 = D0; w1 = D1; w2 = D2;
        src_req = 3'b000;
        pin_en  = 1'b0;
        pin_sel = 2'd0;
        reset   = 1'b1;
        repeat (2) @(posedge clock_27mhz);
        #1;
        check("reset data", disp_data, 64'd0);
        check("reset valid", 64'(disp_valid), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            src_req = vecs[i].req;
            tick();
            check($sformatf("row%0d ack", i), 64'(src_ack), 64'(vecs[i].ack));
            check($sformatf("row%0d owner", i), 64'(disp_owner), 64'(vecs[i].owner));
            check($sformatf("row%0d busy", i), 64'(hold_busy), 64'(vecs[i].busy));
            check($sformatf("row%0d valid", i), 64'(disp_valid), 64'(vecs[i].valid));
            check($sformatf("row%0d data", i), disp_data, exp_word(vecs[i].dsel));
        end

        // Test 3: get owner 0 into OPEN, then req0+req1 together.
        src_req = 3'b001;
        tick();
        check("t3 grant0 ack", 64'(src_ack), 64'b001);
        check("t3 grant0 owner", 64'(disp_owner), 64'd0);
        src_req = 3'b000;
        wait_open("t3 open after owner0");
        src_req = 3'b011;
        tick();
        check("t3 simul ack", 64'(src_ack), 64'b010);
        check("t3 simul owner", 64'(disp_owner), 64'd1);
        src_req = 3'b001;
        first_k = 0;
        for (int k = 1; k <= 20 && first_k == 0; k++) begin
            tick();
            if (src_ack[0]) first_k = k;
        end
        check("t3 ack0 delay", 64'(first_k), 64'd9);

        // Owner refresh mid-hold: new word, ack, but hold not restarted.
        src_req = 3'b000;
        tick();
        tick();
        w0 = D0B;
        src_req = 3'b001;
        tick();
        check("refresh ack", 64'(src_ack), 64'b001);
        check("refresh data", disp_data, D0B);
        check("refresh busy", 64'(hold_busy), 64'd1);
        src_req = 3'b000;
        n = 0;
        while (hold_busy && n < 30) begin
            tick();
            n++;
        end
        check("refresh hold left", 64'(n), 64'd5);
        w0 = D0;

        // Test 6: reset during SHOW with owner 2.
        src_req = 3'b100;
        tick();
        check("t6 grant2 ack", 64'(src_ack), 64'b100);
        check("t6 grant2 owner", 64'(disp_owner), 64'd2);
        src_req = 3'b000;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("t6 async data", disp_data, 64'd0);
        check("t6 async owner", 64'(disp_owner), 64'd0);
        check("t6 async valid", 64'(disp_valid), 64'd0);
        check("t6 async busy", 64'(hold_busy), 64'd0);
        check("t6 async ack", 64'(src_ack), 64'd0);
        @(posedge clock_27mhz);
        @(posedge clock_27mhz);
        #1 reset = 1'b0;
        tick();
        check("t6 idle valid", 64'(disp_valid), 64'd0);
        src_req = 3'b110;
        tick();
        check("t6 rr0 ack", 64'(src_ack), 64'b010);
        check("t6 rr0 owner", 64'(disp_owner), 64'd1);
        check("t6 rr0 data", disp_data, D1);
        src_req = 3'b000;

        // Test 4: all requests held from a fresh reset; owners rotate.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        src_req = 3'b111;
        nev = 0;
        multi = 0;
        last_owner = 2'd3;
        for (int i = 0; i < 4; i++) begin
            ev_owner[i] = 2'd3;
            ev_t[i] = 0;
        end
        for (int t = 1; t <= 60; t++) begin
            tick();
            if ($countones(src_ack) > 1) multi++;
            if (src_ack != 3'b000 && disp_owner != last_owner) begin
                if (nev < 4) begin
                    ev_owner[nev] = disp_owner;
                    ev_t[nev] = t;
                end
                nev++;
                last_owner = disp_owner;
            end
        end
        check("t4 one ack per cycle", 64'(multi), 64'd0);
        check("t4 enough grants", 64'(nev >= 4), 64'd1);
        check("t4 owner0", 64'(ev_owner[0]), 64'd0);
        check("t4 owner1", 64'(ev_owner[1]), 64'd1);
        check("t4 owner2", 64'(ev_owner[2]), 64'd2);
        check("t4 owner3", 64'(ev_owner[3]), 64'd0);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t4 gap%0d", i), 64'((ev_t[i] - ev_t[i-1]) >= int'(MIN_HOLD)),
                  64'd1);
        end

        // Test 5: pin to source 2, then to an out-of-range index.
        src_req = 3'b000;
        wait_open("t5 open");
        pin_en = 1'b1;
        pin_sel = 2'd2;
        src_req = 3'b011;
        nacks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (src_ack != 3'b000) nacks++;
        end
        check("t5 pinned away acks", 64'(nacks), 64'd0);
        src_req = 3'b111;
        tick();
        check("t5 pinned ack", 64'(src_ack), 64'b100);
        check("t5 pinned owner", 64'(disp_owner), 64'd2);
        src_req = 3'b011;
        wait_open("t5 open after pin");
        pin_sel = 2'd3;
        src_req = 3'b111;
        nacks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (src_ack != 3'b000) nacks++;
        end
        check("t5 pin3 acks", 64'(nacks), 64'd0);
        check("t5 pin3 data", disp_data, D2);
        check("t5 pin3 busy", 64'(hold_busy), 64'd0);
        pin_en = 1'b0;
        tick();
        check("t5 unpin ack", 64'(src_ack), 64'b001);
        check("t5 unpin owner", 64'(disp_owner), 64'd0);
        src_req = 3'b000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
